pc_fetch_ctrl: RTL

Sequencer that owns the program counter and drives instruction fetch for the RV core. It holds the PC register and runs the instruction-memory request/acknowledge handshake. It presents fetched instructions to decode with a valid/ready handshake and applies branch/UI/jump redirects from execute. It sits between instruction memory and decode, and replaces free-running next-PC logic with a stall- and redirect-aware controller.

---
 rtl/pc_ctrl_pkg.sv | 30 +++
 rtl/pc_target_gen.sv | 34 +++
 rtl/pc_fetch_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC / instruction-fetch controller.
// Holds the FSM state enum, redirect-select encodings, the default reset PC
// and the fetched-instruction payload struct.
package pc_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [SEL_W-1:0] SEL_SEQ = 2'b00;
  localparam logic [SEL_W-1:0] SEL_BR  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_UI  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_JMP = 2'b11;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] SEQ_STEP         = 32'd4;

  // Instruction word plus the PC it was fetched from, as handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_pkt_t;

endpackage

// File: rtl/pc_target_gen.sv
// Redirect target generator (combinational).
// Ports: sel picks the offset (seq +4 / branch / UI / jump), base is the PC
// of the redirecting instruction; target_c = base + offset (mod 2^32) and
// misaligned_c flags a target that is not word aligned.
module pc_target_gen
  import pc_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic [XLEN-1:0]  base,
  input  logic [XLEN-1:0]  br_offset,
  input  logic [XLEN-1:0]  ui_offset,
  input  logic [XLEN-1:0]  jump_offset,
  output logic [XLEN-1:0]  target_c,
  output logic             misaligned_c
);

  logic [XLEN-1:0] offset;

  // Offset select
  always_comb begin
    offset = SEQ_STEP;
    case (sel)
      SEL_SEQ: offset = SEQ_STEP;
      SEL_BR:  offset = br_offset;
      SEL_UI:  offset = ui_offset;
      SEL_JMP: offset = jump_offset;
      default: offset = SEQ_STEP;
    endcase
  end

  assign target_c     = XLEN'(base + offset);
  assign misaligned_c = |target_c[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter owner and instruction-fetch sequencer.
// Ports: clock / Reset (async, active-low); imem_req/imem_addr/imem_ack/
// imem_rdata form the instruction-memory handshake; inst_valid/inst_out/
// inst_pc/inst_ready form the decode handshake; redirect/redirect_sel/
// redirect_base/*_offset carry execute redirects; fault/fault_pc report a
// misaligned target and fault_clear restarts fetch at RESET_PC.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clock,
  input  logic             Reset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst_out,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             inst_ready,
  input  logic             redirect,
  input  logic [SEL_W-1:0] redirect_sel,
  input  logic [XLEN-1:0]  redirect_base,
  input  logic [XLEN-1:0]  Br_offset,
  input  logic [XLEN-1:0]  UI_offset,
  input  logic [XLEN-1:0]  Jump_offset,
  output logic             fault,
  output logic [XLEN-1:0]  fault_pc,
  input  logic             fault_clear
);

  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] pend_pc, pend_pc_d;   // target waiting for the outstanding ack
  logic            drop, drop_d;         // outstanding fetch must be discarded
  logic            fpend, fpend_d;       // pending target is misaligned
  fetch_pkt_t      held, held_d;
  logic [XLEN-1:0] fault_pc_d;
  logic            imem_req_d, inst_valid_d, fault_d;
  logic [XLEN-1:0] tgt_c;
  logic            tgt_mis_c;

  pc_target_gen u_tgt (
    .sel          (redirect_sel),
    .base         (redirect_base),
    .br_offset    (Br_offset),
    .ui_offset    (UI_offset),
    .jump_offset  (Jump_offset),
    .target_c     (tgt_c),
    .misaligned_c (tgt_mis_c)
  );

  // State and registered outputs
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      drop       <= 1'b0;
      fpend      <= 1'b0;
      held       <= '0;
      fault_pc   <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      pend_pc    <= pend_pc_d;
      drop       <= drop_d;
      fpend      <= fpend_d;
      held       <= held_d;
      fault_pc   <= fault_pc_d;
      imem_req   <= imem_req_d;
      inst_valid <= inst_valid_d;
      fault      <= fault_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    pend_pc_d  = pend_pc;
    drop_d     = drop;
    fpend_d    = fpend;
    held_d     = held;
    fault_pc_d = fault_pc;
    unique case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            // A same-cycle redirect overrides any pending target.
            pc_d    = tgt_c;
            drop_d  = 1'b0;
            fpend_d = 1'b0;
            if (tgt_mis_c) begin
              fault_pc_d = tgt_c;
              state_d    = FAULT;
            end
          end else if (drop) begin
            pc_d    = pend_pc;
            drop_d  = 1'b0;
            fpend_d = 1'b0;
            if (fpend) begin
              fault_pc_d = pend_pc;
              state_d    = FAULT;
            end
          end else begin
            held_d.insn = imem_rdata;
            held_d.pc   = pc;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          // Address stays put until the outstanding request is acked.
          pend_pc_d = tgt_c;
          drop_d    = 1'b1;
          fpend_d   = tgt_mis_c;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d = tgt_c;
          if (tgt_mis_c) begin
            fault_pc_d = tgt_c;
            state_d    = FAULT;
          end else begin
            state_d = FETCH;
          end
        end else if (inst_ready) begin
          pc_d    = XLEN'(pc + SEQ_STEP);
          state_d = FETCH;
        end
      end
      FAULT: begin
        if (fault_clear) begin
          pc_d    = RESET_PC;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values, registered alongside the state
  always_comb begin
    imem_req_d   = 1'b0;
    inst_valid_d = 1'b0;
    fault_d      = 1'b0;
    unique case (state_d)
      FETCH:   imem_req_d   = 1'b1;
      HOLD:    inst_valid_d = 1'b1;
      FAULT:   fault_d      = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;
  assign inst_out  = held.insn;
  assign inst_pc   = held.pc;

endmodule
